pps_monitor: RTL and testbench
==============================

Name: pps_monitor

Overview:
- Receive end of the 1 PPS-style toggle signal used in the design.
- Synchronises an asynchronous PPS input and measures the clock cycles between successive transitions.
- Checks each period against a nominal window; declares lock after N consecutive good periods and loss when a transition is missing.
- Sits in the PL on the board clock and feeds status to LEDs and PS-visible registers.

Parameters:
- NOMINAL, 50000000, expected cycles between input transitions (toggle half-period)
- TOL, 500, allowed ± deviation in cycles
- LOCK_COUNT, 4, consecutive in-window periods required to lock (1..15)
- FILTER_LEN, 8, stability cycles for glitch filter (used only with macro)

Ports:
- iclk  input  1  system clock, all logic on rising edge
- irst_n  input  1  synchronous reset, active-low
- ipps  input  1  asynchronous PPS toggle input
- operiod  output  32  last measured period in cycles
- operiod_valid  output  1  one-cycle pulse when operiod updates
- operiod_err  output  1  one-cycle pulse when a measured period is outside the window
- olocked  output  1  level; high while in LOCKED
- olost  output  1  sticky level; set on timeout, cleared on next transition or reset

Behaviour:
- Reset: irst_n sampled low at a rising edge clears all state. Outputs: operiod=0, operiod_valid=0, operiod_err=0, olocked=0, olost=0; FSM=IDLE; cnt=0; good=0. The synchroniser flops reset to 0. Reset mid-measurement discards the partial count.
- Input path: 2-flop synchroniser, then a delay flop. The edge pulse is sync XOR delayed, so both transitions count.
- Edge latency: an ipps change is seen as an edge 3 cycles later.
- cnt is 32-bit. On an edge cycle it clears to 0; otherwise it increments, saturating at 0xFFFFFFFF.
- Period arithmetic: on an edge, period = cnt+1. This equals the exact cycle distance between the two edges.
- Window: in-window when NOMINAL-TOL ≤ period ≤ NOMINAL+TOL. Compare in 33 bits, with no wrap.
- Timeout: when not in IDLE and cnt+1 reaches NOMINAL+TOL+1 with no edge, the block declares loss.
- FSM states:
  - IDLE: no reference edge. On an edge, go to ACQUIRE; no period is reported.
  - ACQUIRE: on an edge, report the period (operiod_valid=1).
    - In window: good+1; if good+1 == LOCK_COUNT, go to LOCKED.
    - Out of window: operiod_err=1, good=0, stay in ACQUIRE.
    - Timeout: olost=1, good=0, go to IDLE.
  - LOCKED: on an edge, report the period.
    - Out of window: operiod_err=1, good=0, olocked drops next cycle, go to ACQUIRE.
    - Timeout: olost=1, go to IDLE.
- Output timing: operiod, operiod_valid and operiod_err are registered and assert 1 cycle after the edge cycle. olocked follows the FSM register.
- olost clears on the first edge after being set. That edge is the IDLE→ACQUIRE transition.
- Edge and timeout in the same cycle: the edge wins and no timeout is declared.
- Saturated cnt never wraps to a false in-window value.

Optional Feature:
- Macro: PPS_MON_GLITCH_FILTER_EN.
- Defined: a filter is inserted after the synchroniser. The filtered level changes only after the synchronised input differs from it for FILTER_LEN consecutive cycles, using a counter ≥ clog2(FILTER_LEN+1) bits. Edge latency becomes 3+FILTER_LEN cycles. Pulses shorter than FILTER_LEN cycles are ignored.
- Undefined: no filter logic; latency is 3 cycles; FILTER_LEN is unused.

Decomposition:
- Package pps_pkg holds:
  - FSM state typedef (IDLE, ACQUIRE, LOCKED; 2-bit encoding)
  - PPS_CNT_W=32
  - default NOMINAL/TOL constants shared with the generator, 50000000 at 50 MHz
- One natural sub-module: pps_sync_edge. It contains the synchroniser, the optional glitch filter and the edge pulse output.

Test Plan (simulation params NOMINAL=100, TOL=2, LOCK_COUNT=3, unless noted):
- Reset: hold irst_n=0 for 5 cycles while ipps toggles. Required: all outputs 0. After release, the first toggle gives no operiod_valid.
- Clean lock: toggle ipps every 100 cycles. Required: operiod=100 pulses from the 2nd toggle; olocked rises after the 3rd valid period. No operiod_err.
- Window edges: periods 98, 102, 97, 103. Required: 98 and 102 are accepted; 97 and 103 give operiod_err and reset good to 0.
- Loss: lock, then stop toggling. Required: olost=1 and olocked=0 when cnt+1 reaches 103 (103 cycles after the last edge). The next toggle clears olost with no period report. Next period 100 → operiod_valid.
- Reset mid-run: assert irst_n=0 while LOCKED at cnt=50. Required: all outputs 0 the next cycle; re-acquire needs 1+3 toggles.
- Filter (macro on, FILTER_LEN=4): a 3-cycle ipps glitch is ignored. A real toggle reports its edge 7 cycles after the input change; operiod is unchanged at 100.

Source files
------------

// File: rtl/pps_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pps_pkg
// Description : Shared definitions for the PPS receive monitor. Holds the
//               counter width, default timing constants shared with the PPS
//               generator (50 MHz board clock), the monitor FSM state type
//               and the period-window helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pps_pkg;

  // Width of the free-running cycle counter and of the reported period.
  localparam int PPS_CNT_W = 32;

  // Defaults matching the generator: one toggle every 50e6 cycles at 50 MHz.
  localparam int unsigned PPS_DEFAULT_NOMINAL    = 32'd50_000_000;
  localparam int unsigned PPS_DEFAULT_TOL        = 32'd500;
  localparam int unsigned PPS_DEFAULT_LOCK_COUNT = 32'd4;
  localparam int unsigned PPS_DEFAULT_FILTER_LEN = 32'd8;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no reference edge seen yet
    ST_ACQUIRE = 2'd1,  // counting consecutive good periods
    ST_LOCKED  = 2'd2   // enough good periods seen in a row
  } pps_state_e;

  // Inclusive window test carried out one bit wider than the counter so a
  // saturated count plus one can never alias back into the window.
  function automatic logic pps_in_window(
    input logic [PPS_CNT_W:0] period,
    input logic [PPS_CNT_W:0] lo,
    input logic [PPS_CNT_W:0] hi
  );
    return (period >= lo) && (period <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pps_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pps_sync_edge
// Description : Brings the asynchronous PPS toggle into the clock domain with
//               a two-flop synchroniser, optionally debounces it, and emits a
//               one-cycle pulse on every transition (rising and falling).
//               Optional glitch filter enabled by macro
//               PPS_MON_GLITCH_FILTER_EN.
// Ports       : clk_i   - system clock, rising edge
//               rst_ni  - synchronous reset, active low
//               pps_i   - asynchronous PPS toggle input
//               edge_o  - combinational one-cycle pulse per input transition
// Latency     : input change to edge_o cycle is 3 clocks without the filter
//               and 3 + FILTER_LEN clocks with it.
// Revision    : 1.0 - initial release
// ============================================================================
module pps_sync_edge #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pps_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;
  logic w_level;

  // Two-flop synchroniser; both stages clear on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pps_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PPS_MON_GLITCH_FILTER_EN
  // The filtered level follows the synchronised input only once the two have
  // disagreed for FILTER_LEN consecutive cycles; any agreement restarts the
  // count, so shorter pulses never reach the edge detector.
  localparam int unsigned FILT_CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [FILT_CNT_W-1:0] FILT_LAST =
    (FILTER_LEN == 0) ? '0 : FILT_CNT_W'(FILTER_LEN - 1);

  logic                  filt_q;
  logic                  filt_d;
  logic [FILT_CNT_W-1:0] fcnt_q;
  logic [FILT_CNT_W-1:0] fcnt_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q >= FILT_LAST) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign w_level = filt_q;
`else
  // No filter: the synchronised level drives the edge detector directly.
  logic filter_len_unused;
  assign filter_len_unused = (FILTER_LEN != 0);
  assign w_level = sync2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dly_q <= 1'b0;
    end else begin
      dly_q <= w_level;
    end
  end

  // XOR against the delayed copy so both transitions of the toggle count.
  assign edge_o = w_level ^ dly_q;

endmodule
`default_nettype wire

// File: rtl/pps_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pps_monitor
// Description : Receive-side monitor for the 1 PPS toggle. Measures the clock
//               cycles between successive input transitions, checks each
//               period against NOMINAL +/- TOL, declares lock after LOCK_COUNT
//               consecutive good periods and flags loss when a transition is
//               overdue. Optional input glitch filter enabled by macro
//               PPS_MON_GLITCH_FILTER_EN (uses FILTER_LEN).
// Ports       : iclk          - system clock, rising edge
//               irst_n        - synchronous reset, active low
//               ipps          - asynchronous PPS toggle input
//               operiod       - last measured period in cycles
//               operiod_valid - one-cycle pulse when operiod updates
//               operiod_err   - one-cycle pulse for an out-of-window period
//               olocked       - high while in LOCKED
//               olost         - sticky timeout flag, cleared by next edge
// Revision    : 1.0 - initial release
// ============================================================================
module pps_monitor
  import pps_pkg::*;
#(
  parameter int unsigned NOMINAL    = PPS_DEFAULT_NOMINAL,
  parameter int unsigned TOL        = PPS_DEFAULT_TOL,
  parameter int unsigned LOCK_COUNT = PPS_DEFAULT_LOCK_COUNT,
  parameter int unsigned FILTER_LEN = PPS_DEFAULT_FILTER_LEN
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  input  logic                 ipps,
  output logic [PPS_CNT_W-1:0] operiod,
  output logic                 operiod_valid,
  output logic                 operiod_err,
  output logic                 olocked,
  output logic                 olost
);

  localparam int unsigned CW1 = PPS_CNT_W + 1;

  // Window bounds and timeout threshold, all one bit wider than the counter.
  localparam logic [PPS_CNT_W:0] WIN_LO =
    (NOMINAL > TOL) ? CW1'(NOMINAL - TOL) : '0;
  localparam logic [PPS_CNT_W:0] WIN_HI     = CW1'(NOMINAL) + CW1'(TOL);
  localparam logic [PPS_CNT_W:0] TIMEOUT_AT = WIN_HI + CW1'(1);
  localparam logic [3:0]         LOCK_GOAL  = 4'(LOCK_COUNT);

  pps_state_e           state_q;
  pps_state_e           state_d;
  logic [PPS_CNT_W-1:0] cnt_q;
  logic [PPS_CNT_W-1:0] cnt_d;
  logic [3:0]           good_q;
  logic [3:0]           good_d;
  logic [PPS_CNT_W-1:0] period_q;
  logic [PPS_CNT_W-1:0] period_d;
  logic                 valid_q;
  logic                 valid_d;
  logic                 err_q;
  logic                 err_d;
  logic                 lost_q;
  logic                 lost_d;

  logic                 w_edge;
  logic [PPS_CNT_W:0]   w_cnt_inc;
  logic [PPS_CNT_W-1:0] w_period;
  logic [3:0]           w_good_inc;
  logic                 w_in_win;
  logic                 w_timeout;

  pps_sync_edge #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_edge (
    .clk_i  (iclk),
    .rst_ni (irst_n),
    .pps_i  (ipps),
    .edge_o (w_edge)
  );

  // cnt holds (cycles since last edge) - 1, so cnt+1 is the exact distance
  // between two edges when the second one arrives.
  assign w_cnt_inc  = {1'b0, cnt_q} + CW1'(1);
  // Only reachable once cnt has saturated; report the largest value instead
  // of letting the top bit drop and leave a small number behind.
  assign w_period   = w_cnt_inc[PPS_CNT_W] ? '1 : w_cnt_inc[PPS_CNT_W-1:0];
  assign w_good_inc = good_q + 4'd1;
  assign w_in_win   = pps_in_window(w_cnt_inc, WIN_LO, WIN_HI);
  // An edge in the same cycle as the threshold wins over the timeout.
  assign w_timeout  = (state_q != ST_IDLE) && !w_edge && (w_cnt_inc >= TIMEOUT_AT);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    // Any edge ends a loss condition; timeouts below re-arm it.
    lost_d   = w_edge ? 1'b0 : lost_q;

    if (w_edge) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + PPS_CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // First edge is only a reference point; nothing to report yet.
        if (w_edge) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end

      ST_ACQUIRE: begin
        if (w_edge) begin
          valid_d  = 1'b1;
          period_d = w_period;
          if (w_in_win) begin
            good_d = w_good_inc;
            if (w_good_inc == LOCK_GOAL) begin
              state_d = ST_LOCKED;
            end
          end else begin
            err_d  = 1'b1;
            good_d = '0;
          end
        end else if (w_timeout) begin
          lost_d  = 1'b1;
          good_d  = '0;
          state_d = ST_IDLE;
        end
      end

      ST_LOCKED: begin
        if (w_edge) begin
          valid_d  = 1'b1;
          period_d = w_period;
          if (!w_in_win) begin
            err_d   = 1'b1;
            good_d  = '0;
            state_d = ST_ACQUIRE;
          end
        end else if (w_timeout) begin
          lost_d  = 1'b1;
          good_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
    end
  end

  assign operiod       = period_q;
  assign operiod_valid = valid_q;
  assign operiod_err   = err_q;
  assign olocked       = (state_q == ST_LOCKED);
  assign olost         = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_pps_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pps_monitor
// Description : Self-checking bench for pps_monitor with NOMINAL=100, TOL=2,
//               LOCK_COUNT=3, FILTER_LEN=4. Toggle gaps come from a vector
//               table; each expected period report is queued when the toggle
//               is driven and compared when operiod_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pps_monitor;

  localparam int unsigned NOMINAL    = 100;
  localparam int unsigned TOL        = 2;
  localparam int unsigned LOCK_COUNT = 3;
  localparam int unsigned FILTER_LEN = 4;
`ifdef PPS_MON_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILTER_LEN;
`else
  localparam int LAT = 3;
`endif

  logic        iclk   = 1'b0;
  logic        irst_n = 1'b0;
  logic        ipps   = 1'b0;
  logic [31:0] operiod;
  logic        operiod_valid;
  logic        operiod_err;
  logic        olocked;
  logic        olost;

  pps_monitor #(
    .NOMINAL    (NOMINAL),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .ipps          (ipps),
    .operiod       (operiod),
    .operiod_valid (operiod_valid),
    .operiod_err   (operiod_err),
    .olocked       (olocked),
    .olost         (olost)
  );

  always #5 iclk = ~iclk;

  // gap: cycles since the previous toggle; report/err: expected period report
  // for this toggle; locked: olocked level once the toggle has been processed.
  typedef struct {
    int gap;
    bit report;
    bit err;
    bit locked;
  } vec_t;

  typedef struct {
    logic [31:0] period;
    bit          err;
  } exp_t;

  vec_t vecs [0:18];
  exp_t exp_q[$];
  int   n_checks    = 0;
  int   n_fails     = 0;
  int   ticks_since = 0;

  task automatic tick();
    @(posedge iclk);
    #1;
    ticks_since++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic toggle();
    ipps = ~ipps;
    ticks_since = 0;
  endtask

  task automatic run_rows(input int first, input int last);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      while (ticks_since < vecs[i].gap) tick();
      toggle();
      if (vecs[i].report) begin
        e.period = 32'(vecs[i].gap);
        e.err    = vecs[i].err;
        exp_q.push_back(e);
      end
      repeat (LAT + 2) tick();
      check($sformatf("row%0d olocked", i), 32'(olocked), 32'(vecs[i].locked));
    end
  endtask

  // Scoreboard: every report must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge iclk);
      #1;
      if (operiod_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_report: operiod_valid=1 period=%0d, expected no report (t=%0t)",
                   operiod, $time);
        end else begin
          e = exp_q.pop_front();
          check("report period", operiod, e.period);
          check("report err", 32'(operiod_err), 32'(e.err));
        end
      end else if (operiod_err) begin
        n_checks++;
        n_fails++;
        $display("FAIL lone_err: operiod_err=1 without operiod_valid, expected 0 (t=%0t)", $time);
      end
    end
  end

  initial begin
    // Lock from IDLE: first toggle is a reference only.
    vecs[0]  = '{20,  0, 0, 0};
    vecs[1]  = '{100, 1, 0, 0};
    vecs[2]  = '{100, 1, 0, 0};
    vecs[3]  = '{100, 1, 0, 1};
    // Window boundaries; 103 also coincides with the timeout threshold.
    vecs[4]  = '{98,  1, 0, 1};
    vecs[5]  = '{102, 1, 0, 1};
    vecs[6]  = '{97,  1, 1, 0};
    vecs[7]  = '{103, 1, 1, 0};
    vecs[8]  = '{100, 1, 0, 0};
    vecs[9]  = '{100, 1, 0, 0};
    vecs[10] = '{100, 1, 0, 1};
    // Recovery after loss.
    vecs[11] = '{200, 0, 0, 0};
    vecs[12] = '{100, 1, 0, 0};
    vecs[13] = '{100, 1, 0, 0};
    vecs[14] = '{100, 1, 0, 1};
    // Re-acquire after reset.
    vecs[15] = '{150, 0, 0, 0};
    vecs[16] = '{100, 1, 0, 0};
    vecs[17] = '{100, 1, 0, 0};
    vecs[18] = '{100, 1, 0, 1};

    // Reset held while ipps toggles; ends low so release creates no edge.
    irst_n = 1'b0;
    ipps   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) ipps = ~ipps;
    end
    check("reset operiod", operiod, 32'd0);
    check("reset operiod_valid", 32'(operiod_valid), 32'd0);
    check("reset operiod_err", 32'(operiod_err), 32'd0);
    check("reset olocked", 32'(olocked), 32'd0);
    check("reset olost", 32'(olost), 32'd0);
    irst_n = 1'b1;
    ticks_since = 0;

    run_rows(0, 3);
    run_rows(4, 10);

    // Loss: stop toggling; timeout lands 103 cycles after the last edge.
    while (ticks_since < LAT + 102) tick();
    check("pre-timeout olost", 32'(olost), 32'd0);
    check("pre-timeout olocked", 32'(olocked), 32'd1);
    tick();
    check("timeout olost", 32'(olost), 32'd1);
    check("timeout olocked", 32'(olocked), 32'd0);
    repeat (50) tick();
    check("sticky olost", 32'(olost), 32'd1);
    run_rows(11, 11);
    check("olost cleared by edge", 32'(olost), 32'd0);
    run_rows(12, 14);

    // Reset while LOCKED with cnt = 50.
    while (ticks_since < LAT + 50) tick();
    irst_n = 1'b0;
    ipps   = 1'b0;
    tick();
    check("midrun reset operiod", operiod, 32'd0);
    check("midrun reset operiod_valid", 32'(operiod_valid), 32'd0);
    check("midrun reset operiod_err", 32'(operiod_err), 32'd0);
    check("midrun reset olocked", 32'(olocked), 32'd0);
    check("midrun reset olost", 32'(olost), 32'd0);
    repeat (3) tick();
    irst_n = 1'b1;
    run_rows(15, 18);
    check("operiod holds", operiod, 32'd100);

    // Edge latency, with a short glitch first when the filter is built in.
    while (ticks_since < 40) tick();
`ifdef PPS_MON_GLITCH_FILTER_EN
    ipps = ~ipps;
    repeat (3) tick();
    ipps = ~ipps;
`endif
    while (ticks_since < 100) tick();
    toggle();
    exp_q.push_back('{32'd100, 1'b0});
    repeat (LAT - 1) tick();
    check("latency early valid", 32'(operiod_valid), 32'd0);
    tick();
    check("latency valid", 32'(operiod_valid), 32'd1);
    check("latency operiod", operiod, 32'd100);
    check("latency olocked", 32'(olocked), 32'd1);

    repeat (5) tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
